// File: rtl/noc_pkg.sv
// Shared flit format for the NoC endpoint and router.
// Defines the flit layout, field positions and a flit builder.
package noc_pkg;

    localparam int FLIT_W = 16;

    // Field positions inside a flit, shared with router routing logic.
    localparam int PAYLOAD_LSB = 8;
    localparam int DEST_X_LSB  = 4;
    localparam int DEST_Y_LSB  = 0;
    localparam int COORD_W     = 4;
    localparam int PAYLOAD_W   = 8;

    typedef struct packed {
        logic [7:0] payload;
        logic [3:0] dest_x;
        logic [3:0] dest_y;
    } flit_t;

    function automatic flit_t make_flit(
        input logic [7:0] payload,
        input logic [3:0] dest_x,
        input logic [3:0] dest_y
    );
        flit_t f;
        f.payload = payload;
        f.dest_x  = dest_x;
        f.dest_y  = dest_y;
        return f;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data, full, empty.
// A write while full is accepted only if a pop happens the same cycle.
module noc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rd_ok = rd_en && !empty;
    // Full plus a simultaneous pop frees the slot being written.
    assign wr_ok = wr_en && (!full || rd_ok);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/noc_endpoint.sv
// NoC local endpoint: credit-based TX injection and buffered RX ejection.
// Ports: host tx_* / rx_*, router link data_o/enable_o/credit_i and
// data_i/valid_i/credit_o, sticky err_overflow/err_misroute/err_credit.
module noc_endpoint
    import noc_pkg::*;
#(
    parameter logic [3:0] XCOORD     = 4'd0,
    parameter logic [3:0] YCOORD     = 4'd0,
    parameter int         TX_CREDITS = 4,
    parameter int         RX_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [3:0]        tx_dest_x,
    input  logic [3:0]        tx_dest_y,
    input  logic [7:0]        tx_payload,
    output logic [FLIT_W-1:0] data_o,
    output logic              enable_o,
    input  logic              credit_i,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              valid_i,
    output logic              credit_o,
    output logic              rx_valid,
    output logic [FLIT_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic              err_overflow,
    output logic              err_misroute,
    output logic              err_credit
);

    localparam int            CW       = $clog2(TX_CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(TX_CREDITS);
    localparam logic [CW-1:0] CRED_ONE = 1;

    logic [CW-1:0] credit_cnt;
    logic          accept;
    logic          pop;
    logic          rx_full;
    logic          rx_empty;
    flit_t         tx_flit;
    flit_t         rx_flit;

    // TX credit counter
    assign tx_ready = (credit_cnt != '0);
    assign accept   = tx_valid & tx_ready;
    assign tx_flit  = make_flit(tx_payload, tx_dest_x, tx_dest_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CRED_MAX;
        end else if (accept && !credit_i) begin
            credit_cnt <= credit_cnt - CRED_ONE;
        end else if (!accept && credit_i && credit_cnt != CRED_MAX) begin
            credit_cnt <= credit_cnt + CRED_ONE;
        end
    end

    // A credit with nothing outstanding means the link lost sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_credit <= 1'b0;
        end else if (credit_i && !accept && credit_cnt == CRED_MAX) begin
            err_credit <= 1'b1;
        end
    end

    // TX output register; data_o holds its last flit while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o   <= '0;
            enable_o <= 1'b0;
        end else begin
            enable_o <= accept;
            if (accept) begin
                data_o <= tx_flit;
            end
        end
    end

    // RX buffer
    noc_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (FLIT_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (valid_i),
        .wr_data (data_i),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign rx_valid = !rx_empty;
    assign pop      = rx_valid & rx_ready;
    assign rx_flit  = data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_o     <= 1'b0;
            err_overflow <= 1'b0;
            err_misroute <= 1'b0;
        end else begin
            credit_o <= pop;
            if (valid_i && rx_full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (valid_i &&
                (rx_flit.dest_x != XCOORD || rx_flit.dest_y != YCOORD)) begin
                err_misroute <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_endpoint.sv
// Scoreboard bench for noc_endpoint (X=1, Y=1, 4 credits, 4 RX slots).
// Stimulus pushes expected flits; a negedge monitor pops and compares.
module tb_noc_endpoint;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_dest_x;
    logic [3:0]  tx_dest_y;
    logic [7:0]  tx_payload;
    logic [15:0] data_o;
    logic        enable_o;
    logic        credit_i;
    logic [15:0] data_i;
    logic        valid_i;
    logic        credit_o;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic        err_overflow;
    logic        err_misroute;
    logic        err_credit;

    int tests = 0;
    int fails = 0;

    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic        prev_pop = 1'b0;

    always #5 clk = ~clk;

    noc_endpoint #(
        .XCOORD     (4'd1),
        .YCOORD     (4'd1),
        .TX_CREDITS (4),
        .RX_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_dest_x    (tx_dest_x),
        .tx_dest_y    (tx_dest_y),
        .tx_payload   (tx_payload),
        .data_o       (data_o),
        .enable_o     (enable_o),
        .credit_i     (credit_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .credit_o     (credit_o),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .err_overflow (err_overflow),
        .err_misroute (err_misroute),
        .err_credit   (err_credit)
    );

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: TX flits, RX pops and credit_o lag, compared at negedge.
    always @(negedge clk) begin
        if (prev_pop || credit_o) begin
            check("credit_o_lag", {15'd0, credit_o}, {15'd0, prev_pop});
        end
        prev_pop = rx_valid && rx_ready;
        if (enable_o) begin
            if (txq.size() == 0) begin
                check("tx_unexpected", data_o, 16'hxxxx);
            end else begin
                check("tx_flit", data_o, txq.pop_front());
            end
        end
        if (rx_valid && rx_ready) begin
            if (rxq.size() == 0) begin
                check("rx_unexpected", rx_data, 16'hxxxx);
            end else begin
                check("rx_flit", rx_data, rxq.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_dest_x = 4'd1;
        tx_dest_y = 4'd2;
        tx_payload = 8'h00;
        credit_i = 1'b0;
        data_i = 16'h0;
        valid_i = 1'b0;
        rx_ready = 1'b0;
        step();
        step();

        // reset values
        check("rst_tx_ready", {15'd0, tx_ready}, 16'd1);
        check("rst_data_o", data_o, 16'h0000);
        check("rst_enable_o", {15'd0, enable_o}, 16'd0);
        check("rst_credit_o", {15'd0, credit_o}, 16'd0);
        check("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
        check("rst_errs", {13'd0, err_overflow, err_misroute, err_credit},
              16'd0);
        rst = 1'b0;

        // four back-to-back flits on full credit
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_payload = 8'hA5 + 8'(i);
            txq.push_back({8'hA5 + 8'(i), 8'h12});
            step();
            check("tx_burst_enable", {15'd0, enable_o}, 16'd1);
        end
        check("tx_ready_after_4", {15'd0, tx_ready}, 16'd0);
        step();
        check("tx_stall_enable", {15'd0, enable_o}, 16'd0);

        // one credit returns, exactly one more flit
        tx_payload = 8'hB5;
        credit_i = 1'b1;
        step();
        credit_i = 1'b0;
        check("credit_ret_ready", {15'd0, tx_ready}, 16'd1);
        txq.push_back(16'hB512);
        step();
        check("credit_ret_enable", {15'd0, enable_o}, 16'd1);
        step();
        check("credit_ret_ready0", {15'd0, tx_ready}, 16'd0);
        check("credit_ret_enable0", {15'd0, enable_o}, 16'd0);

        // accept and credit in the same cycle
        tx_valid = 1'b0;
        credit_i = 1'b1;
        step();
        tx_valid = 1'b1;
        tx_payload = 8'hC5;
        txq.push_back(16'hC512);
        step();
        check("same_cycle_ready", {15'd0, tx_ready}, 16'd1);
        credit_i = 1'b0;
        tx_payload = 8'hD5;
        txq.push_back(16'hD512);
        step();
        check("same_cycle_drain", {15'd0, tx_ready}, 16'd0);
        tx_valid = 1'b0;
        credit_i = 1'b1;
        repeat (4) step();
        credit_i = 1'b0;
        check("credits_restored", {15'd0, tx_ready}, 16'd1);
        check("no_credit_err_yet", {15'd0, err_credit}, 16'd0);

        // RX: three flits then pops
        valid_i = 1'b1;
        data_i = 16'h1011;
        rxq.push_back(16'h1011);
        #1;
        check("rx_no_bypass", {15'd0, rx_valid}, 16'd0);
        step();
        data_i = 16'h2011;
        rxq.push_back(16'h2011);
        step();
        data_i = 16'h3011;
        rxq.push_back(16'h3011);
        step();
        valid_i = 1'b0;
        check("rx_valid_held", {15'd0, rx_valid}, 16'd1);
        check("rx_head", rx_data, 16'h1011);
        rx_ready = 1'b1;
        repeat (3) step();
        rx_ready = 1'b0;
        check("rx_drained", {15'd0, rx_valid}, 16'd0);
        step();

        // fill, write with pop while full, then overflow
        valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = {8'h40 + 8'(i << 4), 8'h11};
            rxq.push_back({8'h40 + 8'(i << 4), 8'h11});
            step();
        end
        data_i = 16'h8011;
        rxq.push_back(16'h8011);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("full_pop_no_err", {15'd0, err_overflow}, 16'd0);
        data_i = 16'h9011;
        step();
        valid_i = 1'b0;
        check("overflow_err", {15'd0, err_overflow}, 16'd1);
        check("overflow_head", rx_data, 16'h5011);
        rx_ready = 1'b1;
        repeat (4) step();
        rx_ready = 1'b0;
        check("overflow_drained", {15'd0, rx_valid}, 16'd0);

        // misroute
        check("no_misroute_yet", {15'd0, err_misroute}, 16'd0);
        valid_i = 1'b1;
        data_i = 16'hE033;
        rxq.push_back(16'hE033);
        step();
        valid_i = 1'b0;
        check("misroute_err", {15'd0, err_misroute}, 16'd1);
        check("misroute_kept", {15'd0, rx_valid}, 16'd1);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;

        // spurious credit at full count; counter must stay at 4
        credit_i = 1'b1;
        step();
        credit_i = 1'b0;
        check("credit_err", {15'd0, err_credit}, 16'd1);
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_payload = 8'h60 + 8'(i);
            txq.push_back({8'h60 + 8'(i), 8'h12});
            step();
        end
        check("credit_sat_ready", {15'd0, tx_ready}, 16'd0);
        tx_valid = 1'b0;

        // reset with counter 1 and two RX entries
        credit_i = 1'b1;
        valid_i = 1'b1;
        data_i = 16'h1111;
        step();
        credit_i = 1'b0;
        data_i = 16'h2211;
        step();
        valid_i = 1'b0;
        check("pre_rst_rx", {15'd0, rx_valid}, 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_rx_valid", {15'd0, rx_valid}, 16'd0);
        check("mid_rst_tx_ready", {15'd0, tx_ready}, 16'd1);
        check("mid_rst_errs",
              {13'd0, err_overflow, err_misroute, err_credit}, 16'd0);
        check("mid_rst_outs", {14'd0, enable_o, credit_o}, 16'd0);
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_payload = 8'h70 + 8'(i);
            txq.push_back({8'h70 + 8'(i), 8'h12});
            step();
        end
        check("mid_rst_cnt4", {15'd0, tx_ready}, 16'd0);
        tx_valid = 1'b0;
        step();
        step();

        check("txq_empty", 16'(txq.size()), 16'd0);
        check("rxq_empty", 16'(rxq.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
